// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RV32I control FSM sequencing fetch/decode/execute/memory/writeback
// with memory wait states and a sticky illegal-instruction trap.
module multicycle_controller #(
   parameter int ALUCTRL_W   = 3,
   parameter bit SUPPORT_BNE = 1'b1,
   parameter bit SUPPORT_LUI = 1'b1,
   parameter bit MEM_WAIT    = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 Zero,
   input  logic                 MemReady,
   output logic                 PCWrite,
   output logic                 AdrSrc,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic [1:0]           ResultSrc,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic                 RegWrite,
   output logic [2:0]           ImmSrc,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 Illegal,
   output logic [3:0]           State
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
      MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
      JAL = 4'd10, EXECU = 4'd11, TRAP = 4'd15
   } state_e;
   state_e state_q, state_d;
   logic mem_rdy, fd_ok, br_ok, br_take;
   logic [3:0] fd_alu, alu;
   assign mem_rdy = MEM_WAIT ? MemReady : 1'b1;
   assign fd_ok = (funct3 inside {3'b000, 3'b010, 3'b110, 3'b111}) ||
                  (ALUCTRL_W == 4 && (funct3 inside {3'b001, 3'b100, 3'b101}));
   assign br_ok = (funct3 == 3'b000) || (SUPPORT_BNE && funct3 == 3'b001);
   assign br_take = funct3[0] ? !Zero : Zero;
   // ALU codes kept 4 bits wide internally; the 3-bit build simply drops the top bit
   assign fd_alu = funct3 == 3'b000 ? ((op[5] & funct7b5) ? 4'b0001 : 4'b0000) :
                   funct3 == 3'b010 ? 4'b0101 :
                   funct3 == 3'b110 ? 4'b0011 :
                   funct3 == 3'b111 ? 4'b0010 :
                   funct3 == 3'b100 ? 4'b0100 :
                   funct3 == 3'b001 ? 4'b0110 :
                   funct3 == 3'b101 ? (funct7b5 ? 4'b1000 : 4'b0111) : 4'b0000;
   assign ALUControl = alu[ALUCTRL_W-1:0];
   assign State = state_q;
   always_ff @(posedge clk) begin
      state_q <= reset ? FETCH : state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:    state_d = mem_rdy ? DECODE : FETCH;
         DECODE: begin
            case (op)
               7'b0000011, 7'b0100011: state_d = MEMADR;
               7'b0110011:             state_d = EXECR;
               7'b0010011:             state_d = EXECI;
               7'b1100011:             state_d = BRANCH;
               7'b1101111:             state_d = JAL;
               7'b0110111:             state_d = SUPPORT_LUI ? EXECU : TRAP;
               default:                state_d = TRAP;
            endcase
         end
         MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  state_d = mem_rdy ? MEMWB : MEMREAD;
         MEMWB:    state_d = FETCH;
         MEMWRITE: state_d = mem_rdy ? FETCH : MEMWRITE;
         EXECR:    state_d = fd_ok ? ALUWB : TRAP;
         EXECI:    state_d = fd_ok ? ALUWB : TRAP;
         EXECU:    state_d = ALUWB;
         ALUWB:    state_d = FETCH;
         BRANCH:   state_d = br_ok ? FETCH : TRAP;
         JAL:      state_d = ALUWB;
         default:  state_d = TRAP;
      endcase
   end
   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      RegWrite  = 1'b0;
      ImmSrc    = 3'b000;
      alu       = 4'b0000;
      Illegal   = 1'b0;
      case (state_q)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_rdy;
            PCWrite   = mem_rdy;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = 3'b010;
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = op[5] ? 3'b001 : 3'b000;
         end
         MEMREAD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         EXECR: begin
            ALUSrcA = 2'b10;
            alu     = fd_alu;
            Illegal = !fd_ok;
         end
         EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu     = fd_alu;
            Illegal = !fd_ok;
         end
         EXECU: begin
            ALUSrcA = 2'b11;
            ALUSrcB = 2'b01;
            ImmSrc  = 3'b100;
         end
         ALUWB:    RegWrite = 1'b1;
         BRANCH: begin
            ALUSrcA = 2'b10;
            alu     = 4'b0001;
            PCWrite = br_ok & br_take;
            Illegal = !br_ok;
         end
         JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         TRAP:     Illegal = 1'b1;
         default:  Illegal = 1'b0;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
      end
   end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams against two controller builds
// (3-bit and 4-bit ALU control), scoreboarded per cycle against an instruction-level model.
module tb_multicycle_controller;
   localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MWB = 4'd4,
                          S_MW = 4'd5, S_ER = 4'd6, S_EI = 4'd7, S_WB = 4'd8, S_BR = 4'd9,
                          S_J = 4'd10, S_EU = 4'd11, S_T = 4'd15;
   logic clk = 1'b0, reset = 1'b1, funct7b5 = 1'b0, Zero = 1'b0, MemReady = 1'b0;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic pcw3, adr3, mw3, irw3, rw3, ill3, pcw4, adr4, mw4, irw4, rw4, ill4;
   logic [1:0] rs3, sa3, sb3, rs4, sa4, sb4;
   logic [2:0] im3, im4, alu3;
   logic [3:0] alu4, st3, st4;
   typedef struct packed {
      logic [3:0] st;
      logic pcw, irw, mw, rw, adr, ill, ca;
      logic [1:0] rs, sa, sb;
      logic [2:0] im;
      logic [3:0] alu;
   } exp_t;
   exp_t q3[$], q4[$];
   logic [3:0] seq3[$], seq4[$];
   logic mrq[$];
   logic [6:0] n_op;
   logic [2:0] n_f3;
   logic n_f7, n_z;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   multicycle_controller u3 (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .MemReady(MemReady), .PCWrite(pcw3), .AdrSrc(adr3), .MemWrite(mw3), .IRWrite(irw3),
      .ResultSrc(rs3), .ALUSrcA(sa3), .ALUSrcB(sb3), .RegWrite(rw3), .ImmSrc(im3),
      .ALUControl(alu3), .Illegal(ill3), .State(st3)
   );
   multicycle_controller #(.ALUCTRL_W(4)) u4 (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
      .MemReady(MemReady), .PCWrite(pcw4), .AdrSrc(adr4), .MemWrite(mw4), .IRWrite(irw4),
      .ResultSrc(rs4), .ALUSrcA(sa4), .ALUSrcB(sb4), .RegWrite(rw4), .ImmSrc(im4),
      .ALUControl(alu4), .Illegal(ill4), .State(st4)
   );
   function automatic bit legal(int w, logic [2:0] f);
      return f == 3'd0 || f == 3'd2 || f == 3'd6 || f == 3'd7 ||
             (w == 4 && (f == 3'd1 || f == 3'd4 || f == 3'd5));
   endfunction
   // add 0, sub 1, and 2, or 3, slt 5, xor 4, sll 6, srl 7, sra 8
   function automatic logic [3:0] fdec(logic [2:0] f, logic o5, logic f7);
      case (f)
         3'd0: return (o5 && f7) ? 4'd1 : 4'd0;
         3'd2: return 4'd5;
         3'd6: return 4'd3;
         3'd7: return 4'd2;
         3'd4: return 4'd4;
         3'd1: return 4'd6;
         3'd5: return f7 ? 4'd8 : 4'd7;
         default: return 4'd0;
      endcase
   endfunction
   function automatic exp_t expect_for(int w, logic [3:0] s, logic rst, logic mr);
      exp_t e;
      e = '0;
      e.st = s;
      e.ca = 1'b1;
      case (s)
         S_F: begin e.sb = 2; e.rs = 2; e.pcw = mr; e.irw = mr; end
         S_D: begin e.sa = 1; e.sb = 1; e.im = 3'd2; end
         S_MA: begin e.sa = 2; e.sb = 1; e.im = op[5] ? 3'd1 : 3'd0; end
         S_MR: e.adr = 1;
         S_MWB: begin e.rs = 1; e.rw = 1; end
         S_MW: begin e.adr = 1; e.mw = 1; end
         S_ER, S_EI: begin
            e.sa = 2;
            e.sb = (s == S_EI) ? 2'd1 : 2'd0;
            e.ca = legal(w, funct3);
            e.alu = fdec(funct3, op[5], funct7b5);
            e.ill = !legal(w, funct3);
         end
         S_EU: begin e.sa = 3; e.sb = 1; e.im = 3'd4; end
         S_WB: e.rw = 1;
         S_BR: begin
            e.sa = 2;
            e.alu = 4'd1;
            e.pcw = (funct3 == 3'd0 && Zero) || (funct3 == 3'd1 && !Zero);
            e.ill = funct3 > 3'd1;
         end
         S_J: begin e.sa = 1; e.sb = 2; e.pcw = 1; end
         S_T: e.ill = 1;
         default: e.ca = 1'b1;
      endcase
      if (rst) begin e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0; end
      return e;
   endfunction
   task automatic chk(string tag, string nm, logic [31:0] a, logic [31:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s %s got=%0d expected=%0d at %0t", tag, nm, a, x, $time);
      end
   endtask
   task automatic cmp(string tag, exp_t e, logic [3:0] st, logic pcw, logic irw, logic mw,
                      logic rw, logic adr, logic ill, logic [1:0] rs, logic [1:0] sa,
                      logic [1:0] sb, logic [2:0] im, logic [3:0] alu);
      chk(tag, "State", 32'(st), 32'(e.st));
      chk(tag, "PCWrite", 32'(pcw), 32'(e.pcw));
      chk(tag, "IRWrite", 32'(irw), 32'(e.irw));
      chk(tag, "MemWrite", 32'(mw), 32'(e.mw));
      chk(tag, "RegWrite", 32'(rw), 32'(e.rw));
      chk(tag, "AdrSrc", 32'(adr), 32'(e.adr));
      chk(tag, "Illegal", 32'(ill), 32'(e.ill));
      chk(tag, "ResultSrc", 32'(rs), 32'(e.rs));
      chk(tag, "ALUSrcA", 32'(sa), 32'(e.sa));
      chk(tag, "ALUSrcB", 32'(sb), 32'(e.sb));
      chk(tag, "ImmSrc", 32'(im), 32'(e.im));
      if (e.ca) chk(tag, "ALUControl", 32'(alu), 32'(e.alu));
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (q3.size() != 0) begin
         e = q3.pop_front();
         cmp("w3", e, st3, pcw3, irw3, mw3, rw3, adr3, ill3, rs3, sa3, sb3, im3, {1'b0, alu3});
      end
      if (q4.size() != 0) begin
         e = q4.pop_front();
         cmp("w4", e, st4, pcw4, irw4, mw4, rw4, adr4, ill4, rs4, sa4, sb4, im4, alu4);
      end
   end
   task automatic cyc(logic [3:0] s3, logic [3:0] s4, logic rst, logic mr);
      @(posedge clk);
      #1;
      op = n_op;
      funct3 = n_f3;
      funct7b5 = n_f7;
      Zero = n_z;
      reset = rst;
      MemReady = mr;
      q3.push_back(expect_for(3, s3, rst, mr));
      q4.push_back(expect_for(4, s4, rst, mr));
   endtask
   task automatic add(logic [3:0] a, logic [3:0] b, logic mr);
      seq3.push_back(a);
      seq4.push_back(b);
      mrq.push_back(mr);
   endtask
   // Phase sequence of one instruction for both builds, from its class and wait counts
   task automatic build(int nf, int nm);
      seq3.delete();
      seq4.delete();
      mrq.delete();
      for (int i = 0; i < nf; i++) add(S_F, S_F, 1'b0);
      add(S_F, S_F, 1'b1);
      add(S_D, S_D, 1'($urandom_range(0, 1)));
      case (n_op)
         7'h03: begin
            add(S_MA, S_MA, 1'($urandom_range(0, 1)));
            for (int i = 0; i < nm; i++) add(S_MR, S_MR, 1'b0);
            add(S_MR, S_MR, 1'b1);
            add(S_MWB, S_MWB, 1'($urandom_range(0, 1)));
         end
         7'h23: begin
            add(S_MA, S_MA, 1'($urandom_range(0, 1)));
            for (int i = 0; i < nm; i++) add(S_MW, S_MW, 1'b0);
            add(S_MW, S_MW, 1'b1);
         end
         7'h33, 7'h13: begin
            add(n_op == 7'h33 ? S_ER : S_EI, n_op == 7'h33 ? S_ER : S_EI, 1'($urandom_range(0, 1)));
            add(legal(3, n_f3) ? S_WB : S_T, legal(4, n_f3) ? S_WB : S_T, 1'($urandom_range(0, 1)));
         end
         7'h63: begin
            add(S_BR, S_BR, 1'($urandom_range(0, 1)));
            if (n_f3 > 3'd1) add(S_T, S_T, 1'($urandom_range(0, 1)));
         end
         7'h6F: begin add(S_J, S_J, 1'b1); add(S_WB, S_WB, 1'b0); end
         7'h37: begin add(S_EU, S_EU, 1'b0); add(S_WB, S_WB, 1'b1); end
         default: add(S_T, S_T, 1'($urandom_range(0, 1)));
      endcase
   endtask
   // t_req: -1 run to completion, -2 random mid-instruction reset, >=0 reset at that cycle
   task automatic run_ins(logic [6:0] o, logic [2:0] f3, logic f7, logic z, int nf, int nm,
                          int hold, int t_req);
      int len, t;
      logic [3:0] l3, l4;
      n_op = o;
      n_f3 = f3;
      n_f7 = f7;
      n_z = z;
      build(nf, nm);
      len = seq3.size();
      t = t_req;
      if (t == -2) t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, len - 1)) : -1;
      for (int i = 0; i < len; i++) begin
         if (i == t) begin
            cyc(seq3[i], seq4[i], 1'b1, mrq[i]);
            return;
         end
         cyc(seq3[i], seq4[i], 1'b0, mrq[i]);
      end
      if (seq3[len-1] == S_T || seq4[len-1] == S_T) begin
         l3 = seq3[len-1] == S_T ? S_T : S_F;
         l4 = seq4[len-1] == S_T ? S_T : S_F;
         for (int i = 0; i < hold; i++) cyc(l3, l4, 1'b0, 1'b0);
         cyc(l3, l4, 1'b1, 1'b0);
      end
   endtask
   initial begin
      logic [6:0] ops [9];
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h37, 7'h7F, 7'h0F};
      n_op = 7'd0; n_f3 = 3'd0; n_f7 = 1'b0; n_z = 1'b0;
      @(posedge clk);
      cyc(S_F, S_F, 1'b1, 1'b0);
      run_ins(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, 0, -1);
      run_ins(7'h03, 3'd2, 1'b0, 1'b0, 2, 1, 0, -1);
      run_ins(7'h63, 3'd0, 1'b0, 1'b1, 0, 0, 0, -1);
      run_ins(7'h63, 3'd1, 1'b0, 1'b1, 0, 0, 0, -1);
      run_ins(7'h63, 3'd1, 1'b0, 1'b0, 0, 0, 0, -1);
      run_ins(7'h23, 3'd2, 1'b0, 1'b0, 0, 3, 0, -1);
      run_ins(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, 20, -1);
      run_ins(7'h33, 3'd4, 1'b0, 1'b0, 0, 0, 3, -1);
      run_ins(7'h13, 3'd1, 1'b0, 1'b0, 1, 0, 2, -1);
      run_ins(7'h33, 3'd0, 1'b1, 1'b0, 0, 0, 0, -1);
      run_ins(7'h33, 3'd5, 1'b1, 1'b0, 0, 0, 2, -1);
      run_ins(7'h33, 3'd3, 1'b0, 1'b0, 0, 0, 2, -1);
      run_ins(7'h63, 3'd4, 1'b0, 1'b0, 0, 0, 2, -1);
      run_ins(7'h37, 3'd0, 1'b0, 1'b0, 0, 0, 0, -1);
      run_ins(7'h6F, 3'd0, 1'b0, 1'b0, 0, 0, 0, -1);
      run_ins(7'h03, 3'd2, 1'b0, 1'b0, 0, 2, 0, 4);
      run_ins(7'h23, 3'd2, 1'b0, 1'b0, 0, 2, 0, 3);
      for (int k = 0; k < 250; k++)
         run_ins(ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), -2);
      repeat (3) @(posedge clk);
      chk("end", "pending", 32'(q3.size() + q4.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised FSM control unit for the multicycle RV32I datapath, the sequential successor to the single-cycle controller. Once per instruction it sequences fetch, decode, execute, memory and writeback steps and drives every datapath enable and mux select. It adds memory wait-state handling via `MemReady`, optional `bne`/`lui`/extended-ALU support, and a sticky illegal-instruction trap.

## Interface
- `ALUCTRL_W`, default 3: width of `ALUControl`; legal values are 3 or 4. With 4, xor/sll/srl/sra are enabled.
- `SUPPORT_BNE`, default 1: when 1, decode `bne`; when 0, funct3=001 branches are illegal.
- `SUPPORT_LUI`, default 1: when 1, decode `lui` (0110111); when 0, it is illegal.
- `MEM_WAIT`, default 1: when 1, honour `MemReady`; when 0, treat `MemReady` as constant 1.

Ports (clock and reset first):
- `clk`  in  1  sole clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  7  instruction opcode from IR
- `funct3`  in  3  IR[14:12]
- `funct7b5`  in  1  IR[30]
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  unified memory has completed the current access this cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0=PC, 1=ALUOut
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  IR and OldPC enable
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALUResult
- `ALUSrcA`  out  2  00=PC, 01=OldPC, 10=A (rs1), 11=zero
- `ALUSrcB`  out  2  00=WriteData (rs2), 01=ImmExt, 10=constant 4
- `RegWrite`  out  1  register file write enable
- `ImmSrc`  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- `ALUControl`  out  ALUCTRL_W  ALU operation
- `Illegal`  out  1  sticky trap flag
- `State`  out  4  current state code, for debug and verification

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, EXECU 11, TRAP 15.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stay in FETCH while !MemReady; go to DECODE on MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add (computes branch target). Next state by `op`:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> EXECU (if SUPPORT_LUI)
  - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add; ImmSrc=I for lw, S for sw. Next is MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1; wait for MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until MemReady, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, funct decode, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, funct decode, then ALUWB.
- EXECU: ALUSrcA=11, ALUSrcB=01, ImmSrc=U, add, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, then FETCH.
  - PCWrite=Zero for beq (funct3 000).
  - PCWrite=!Zero for bne (funct3 001, SUPPORT_BNE).
  - Any other funct3 -> TRAP, PCWrite=0.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB.
- TRAP: Illegal=1 and all write enables 0. Stays in TRAP until reset.
- ALU encodings (zero-extended when ALUCTRL_W=4): add 000, sub 001, and 010, or 011, slt 101.
- Funct decode (EXECR/EXECI):
  - funct3 000: sub if op[5]&funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - With ALUCTRL_W=4 only: 100 xor=0100, 001 sll=0110, 101 srl=0111 or sra=1000 (selected by funct7b5).
  - With ALUCTRL_W=3: funct3 100, 001 and 101 are illegal.
- An illegal funct3 found in EXECR, EXECI or BRANCH suppresses all writes in that cycle, and the next state is TRAP.
- Unlisted outputs default to 0 in every state.

## Timing
- Outputs are Moore decodes of state, except these Mealy terms:
  - PCWrite/IRWrite in FETCH (on MemReady)
  - PCWrite in BRANCH (on Zero)
  - ALUControl and Illegal-transition terms in EXECR/EXECI/BRANCH (on funct3/funct7b5).
- Reset: on the next edge, state=FETCH and Illegal=0. While `reset` is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0, including when reset arrives mid-instruction or in TRAP.
- Cycles per instruction at zero wait: beq/bne 3; R, I, sw, jal and lui 4; lw 5. Each !MemReady cycle in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- MemWrite is asserted continuously through the wait and deasserts the cycle after MemReady is sampled high.

## Test plan
- Reset, then `add` (op=0110011, funct3=000, funct7b5=0) with MemReady=1: State goes 0,1,6,8,0; ALUControl=000 in state 6; RegWrite=1 only in state 8.
- `lw` with MemReady low for 2 cycles in FETCH and 1 cycle in MEMREAD: 8 cycles total; IRWrite pulses once; RegWrite=1 in state 4 with ResultSrc=01.
- `beq` with Zero=1, then `bne` with Zero=1: PCWrite=1 in the first BRANCH state, 0 in the second; both take 3 cycles.
- `sw` with 3 wait cycles: MemWrite high for exactly 4 consecutive cycles with AdrSrc=1.
- op=1111111 -> TRAP; Illegal=1 held for 20 cycles with no write enables; reset clears it to FETCH.
- ALUCTRL_W=3 with funct3=100 -> TRAP; ALUCTRL_W=4 with same input -> ALUControl=0100, then ALUWB.
